alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max cycles waited in WAIT for core_done (legal range 2..255).
REQ-002 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: operation request; sampled only in IDLE.
REQ-005 SHALL have port opcode, input, 2: FP operation select; latched when start is accepted.
REQ-006 SHALL have port in_byte, input, 8: serial operand byte.
REQ-007 SHALL have port in_valid, input, 1: in_byte valid.
REQ-008 SHALL have port in_ready, output, 1: controller accepts in_byte.
REQ-009 SHALL have port out_byte, output, 8: serial result byte.
REQ-010 SHALL have port out_valid, output, 1: out_byte valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts out_byte.
REQ-012 SHALL have port core_a, output, 32: operand A to FP core.
REQ-013 SHALL have port core_b, output, 32: operand B to FP core.
REQ-014 SHALL have port core_op, output, 2: latched opcode to FP core.
REQ-015 SHALL have port core_start, output, 1: one-cycle issue pulse to FP core.
REQ-016 SHALL have port core_done, input, 1: FP core result valid (one-cycle pulse).
REQ-017 SHALL have port core_result, input, 32: FP core result, sampled when core_done=1.
REQ-018 SHALL have port done, output, 1: one-cycle pulse after last result byte accepted.
REQ-019 SHALL have port err, output, 1: last operation timed out.
REQ-020 SHALL have port state, output, 4: current FSM state encoding.

Function
REQ-021 SHALL implement states IDLE=0, LOAD_A=1, LOAD_B=2, ISSUE=3, WAIT=4, UNLOAD=5, DONE=6; encodings 7..15 unreachable and SHALL return to IDLE next cycle.
REQ-022 SHALL, in IDLE with start=1, latch opcode, clear err, clear byte counter, and enter LOAD_A; start in any other state SHALL be ignored.
REQ-023 SHALL drive in_ready=1 only in LOAD_A and LOAD_B; a byte is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-024 SHALL assemble operands little-endian: 1st accepted byte -> bits[7:0], 4th -> bits[31:24]; 2-bit counter wraps 3->0.
REQ-025 SHALL move LOAD_A->LOAD_B on the 4th accepted byte, LOAD_B->ISSUE on the 4th accepted byte of B; in_valid=0 cycles stall without counting.
REQ-026 SHALL assert core_start=1 for exactly the one cycle spent in ISSUE, then enter WAIT.
REQ-027 SHALL hold core_a, core_b, core_op stable from ISSUE until the next accepted start.
REQ-028 SHALL, in WAIT, count cycles from 0; on core_done=1 capture core_result and enter UNLOAD.
REQ-029 SHALL, if count reaches TIMEOUT-1 with core_done=0, load result 0x7FC00000 (qNaN), set err=1, enter UNLOAD.
REQ-030 SHALL give core_done priority over timeout when both occur in the same cycle (err stays 0).
REQ-031 SHALL ignore core_done in every state except WAIT.
REQ-032 SHALL, in UNLOAD, drive out_valid=1 with out_byte = result byte[counter], little-endian; advance counter only when out_ready=1; out_byte SHALL stay stable while stalled.
REQ-033 SHALL enter DONE after the 4th accepted result byte; done=1 for that single cycle; then IDLE.
REQ-034 SHALL hold err until the next accepted start or reset.
REQ-035 SHALL drive state equal to the current FSM encoding every cycle, registered.
REQ-036 SHALL produce latency (no stalls) from start accept to done: 4+4+1+N+4+1 cycles, N = core latency in cycles (>=1).

Reset
REQ-037 SHALL, on rst=1 at a clock edge, force state=IDLE and set in_ready, out_valid, core_start, done, err to 0, and core_a, core_b, core_op, out_byte, counters, result to 0.
REQ-038 SHALL abort any operation mid-flight on reset with no further core_start, out_valid or done until a new start.
REQ-039 SHALL give rst priority over every other input in the same cycle.

Verification
REQ-040 SHALL cover basic op: start, opcode=0, bytes 00 00 80 3F, 00 00 00 40; core returns 0x40400000 after 3 cycles -> core_a=0x3F800000, core_b=0x40000000, one core_start pulse, out bytes 00 00 40 40, done pulse, err=0.
REQ-041 SHALL cover backpressure: in_valid and out_ready toggled every other cycle -> identical bytes and result, out_byte stable while out_ready=0.
REQ-042 SHALL cover timeout: TIMEOUT=8, core_done never asserted -> out bytes 00 00 C0 7F, err=1 until next start.
REQ-043 SHALL cover collision: core_done on the timeout cycle with result 0x12345678 -> out bytes 78 56 34 12, err=0.
REQ-044 SHALL cover reset mid-UNLOAD after 2 bytes -> state=0, out_valid=0, no done; next op completes normally.
REQ-045 SHALL cover spurious inputs: start in WAIT and core_done in IDLE -> no state change, no extra core_start.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Byte-serial sequencer for a 32-bit FP core: gathers two operands, issues one
// operation, waits (with timeout) for the result and streams it back out.
module alu_seq_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  opcode,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic [1:0]  core_op,
    output logic        core_start,
    input  logic        core_done,
    input  logic [31:0] core_result,
    output logic        done,
    output logic        err,
    output logic [3:0]  state
);

    // Handshake: a byte moves on any rising edge where valid and ready are both 1;
    // the producer holds its byte until then, stalls never advance the byte counter.

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_A = 4'd1,
        S_LOAD_B = 4'd2,
        S_ISSUE  = 4'd3,
        S_WAIT   = 4'd4,
        S_UNLOAD = 4'd5,
        S_DONE   = 4'd6
    } state_t;

    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    logic [1:0]  op_q, op_d;
    logic        err_q, err_d;
    logic        in_ready_q, out_valid_q, core_start_q, done_q;
    logic [7:0]  out_byte_q;
    logic        in_acc, out_acc;

    assign in_acc  = in_valid & in_ready_q;
    assign out_acc = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                    op_d    = opcode;
                    err_d   = 1'b0;
                    cnt_d   = 2'd0;
                end
            end
            S_LOAD_A: begin
                if (in_acc) begin
                    a_d[{cnt_q, 3'b000} +: 8] = in_byte;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (in_acc) begin
                    b_d[{cnt_q, 3'b000} +: 8] = in_byte;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wait_d  = 8'd0;
            end
            S_WAIT: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (core_done) begin
                    res_d   = core_result;
                    state_d = S_UNLOAD;
                end else if (wait_q == WAIT_LAST) begin
                    res_d   = QNAN;
                    err_d   = 1'b1;
                    state_d = S_UNLOAD;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_UNLOAD: begin
                if (out_acc) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            wait_q       <= 8'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            res_q        <= 32'd0;
            op_q         <= 2'd0;
            err_q        <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            out_byte_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            op_q         <= op_d;
            err_q        <= err_d;
            // Outputs are decoded from the next state so they line up with the registered state.
            in_ready_q   <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
            out_valid_q  <= (state_d == S_UNLOAD);
            core_start_q <= (state_d == S_ISSUE);
            done_q       <= (state_d == S_DONE);
            if (state_d == S_UNLOAD) out_byte_q <= res_d[{cnt_d, 3'b000} +: 8];
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_byte   = out_byte_q;
    assign core_start = core_start_q;
    assign done       = done_q;
    assign err        = err_q;
    assign core_a     = a_q;
    assign core_b     = b_q;
    assign core_op    = op_q;
    assign state      = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized bench for alu_seq_ctrl: an operation-level model predicts the result
// bytes, error flag and latency; a mock FP core answers after a chosen delay.
module tb_alu_seq_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, out_valid, out_ready;
    logic        core_start, core_done, done, err;
    logic [1:0]  opcode, core_op;
    logic [7:0]  in_byte, out_byte;
    logic [31:0] core_a, core_b, core_result;
    logic [3:0]  state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    alu_seq_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .core_a(core_a), .core_b(core_b), .core_op(core_op),
        .core_start(core_start), .core_done(core_done), .core_result(core_result),
        .done(done), .err(err), .state(state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        core_done = 1'b0;
    endtask

    function automatic bit pick(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 2) == 1;
        return 1'($urandom_range(0, 1));
    endfunction

    // lat = cycles from core_start to core_done (0 = core never answers).
    // stall: 0 none, 1 toggle every other cycle, 2 random.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] res, input int stall,
                          input bit spurious, input int abort_after);
        logic [7:0]  in_bytes[8];
        logic [31:0] exp_res;
        bit          exp_err, fin, aborted;
        int          idx, cd, starts, popped, n_eff, pulses;

        exp_err = (lat == 0) || (lat > TO);
        exp_res = exp_err ? 32'h7FC0_0000 : res;
        n_eff   = exp_err ? TO : lat;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp_res[8*i +: 8]);
            in_bytes[i]     = a[8*i +: 8];
            in_bytes[4 + i] = b[8*i +: 8];
        end

        @(negedge clk);
        idle_inputs();
        start  = 1'b1;
        opcode = op;
        @(negedge clk);
        start  = 1'b0;
        opcode = 2'($urandom);
        check_eq("err_cleared_on_start", 32'(err), 32'd0);
        check_eq("state_load_a", 32'(state), 32'd1);

        idx = 0; cd = 0; starts = 0; popped = 0; fin = 1'b0; aborted = 1'b0;
        for (int c = 1; c <= 400 && !fin; c++) begin
            core_done   = 1'b0;
            core_result = $urandom;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    core_done   = 1'b1;
                    core_result = res;
                end
            end
            if (core_start) begin
                starts++;
                check_eq("core_a", core_a, a);
                check_eq("core_b", core_b, b);
                check_eq("core_op", 32'(core_op), 32'(op));
                if (lat > 0) cd = lat;
            end

            in_valid = pick(stall, c) && (idx < 8);
            in_byte  = in_valid ? in_bytes[idx] : 8'($urandom);
            if (in_valid && in_ready) idx++;

            out_ready = pick(stall, c);
            if (out_valid) begin
                if (exp_q.size() > 0) check_eq("out_byte", 32'(out_byte), 32'(exp_q[0]));
                else check_eq("out_valid_extra", 32'(out_valid), 32'd0);
                if (out_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
            end

            start = spurious && (state == 4'd4);
            if (start) opcode = 2'($urandom);

            if (abort_after > 0 && popped == abort_after) begin
                fin     = 1'b1;
                aborted = 1'b1;
            end else if (done) begin
                fin = 1'b1;
                check_eq("done_state", 32'(state), 32'd6);
                check_eq("bytes_out", 32'(popped), 32'd4);
                check_eq("err_at_done", 32'(err), 32'(exp_err));
                check_eq("core_start_count", 32'(starts), 32'd1);
                check_eq("core_op_latched", 32'(core_op), 32'(op));
                if (stall == 0) check_eq("latency", 32'(c), 32'(14 + n_eff));
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) check_eq("op_completed_in_budget", 32'd0, 32'd1);

        @(negedge clk);
        idle_inputs();
        if (aborted) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_eq("abort_state", 32'(state), 32'd0);
            check_eq("abort_out_valid", 32'(out_valid), 32'd0);
            check_eq("abort_in_ready", 32'(in_ready), 32'd0);
            check_eq("abort_err", 32'(err), 32'd0);
            pulses = 0;
            for (int k = 0; k < 12; k++) begin
                if (done || out_valid || core_start) pulses++;
                @(negedge clk);
            end
            check_eq("no_pulses_after_abort", 32'(pulses), 32'd0);
        end else begin
            check_eq("back_to_idle", 32'(state), 32'd0);
            check_eq("done_single_cycle", 32'(done), 32'd0);
            check_eq("err_held", 32'(err), 32'(exp_err));
            check_eq("core_a_held", core_a, a);
            check_eq("core_b_held", core_b, b);
        end
    endtask

    task automatic idle_glitch();
        @(negedge clk);
        idle_inputs();
        core_done   = 1'b1;
        core_result = $urandom;
        @(negedge clk);
        core_done = 1'b0;
        check_eq("glitch_state", 32'(state), 32'd0);
        check_eq("glitch_core_start", 32'(core_start), 32'd0);
        check_eq("glitch_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        opcode      = 2'd0;
        in_byte     = 8'd0;
        core_result = 32'd0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_core_start", 32'(core_start), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_core_a", core_a, 32'd0);
        check_eq("rst_core_b", core_b, 32'd0);
        check_eq("rst_core_op", 32'(core_op), 32'd0);
        check_eq("rst_out_byte", 32'(out_byte), 32'd0);
        rst = 1'b0;

        run_op(2'd0, 32'h3F80_0000, 32'h4000_0000, 3, 32'h4040_0000, 0, 1'b0, 0);
        run_op(2'd0, 32'h3F80_0000, 32'h4000_0000, 3, 32'h4040_0000, 1, 1'b0, 0);
        run_op(2'd1, $urandom, $urandom, 0, 32'd0, 0, 1'b0, 0);
        repeat (5) @(negedge clk);
        check_eq("err_held_idle", 32'(err), 32'd1);
        run_op(2'd2, $urandom, $urandom, TO, 32'h1234_5678, 0, 1'b0, 0);
        run_op(2'd3, $urandom, $urandom, 5, $urandom, 0, 1'b0, 2);
        run_op(2'd1, $urandom, $urandom, 4, $urandom, 0, 1'b0, 0);
        idle_glitch();
        run_op(2'd2, $urandom, $urandom, 6, $urandom, 0, 1'b1, 0);
        run_op(2'd0, $urandom, $urandom, TO + 2, $urandom, 2, 1'b0, 0);

        repeat (30) begin
            run_op(2'($urandom), $urandom, $urandom, $urandom_range(0, TO + 3), $urandom,
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 3) == 0) idle_glitch();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
